spmv_mem_arbiter: RTL and testbench
===================================

# spmv_mem_arbiter

Schedules the single PE memory request port between three requesters: the MAC result stream (stores), the x-vector cache (loads) and the sparse matrix decoder (loads). It sits between the PE's request FIFOs and the `req_mem_*` port. It also owns the result store address counter and bounds outstanding loads with a credit counter. The PE and its opcode decoder configure and sequence it through a small register/command interface.

## Interface
Parameters:
- `MAX_OUT`, 32: maximum loads issued and not yet answered by `rsp_mem_push`.
- `STARVE_LIMIT`, 16: consecutive cycles a valid decoder request may be passed over before it is forced to win.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `st_valid`/`st_ready`  in/out  1/1  store request handshake from the MAC side.
- `st_data`  in  64  store data.
- `cl_valid`/`cl_ready`  in/out  1/1  cache load handshake.
- `cl_addr`  in  48  cache load address.
- `dl_valid`/`dl_ready`  in/out  1/1  decoder load handshake.
- `dl_addr`  in  48  decoder load address.
- `dl_tag`  in  2  decoder stream tag.
- `cfg_ld`  in  1  write strobe for `cfg_data`.
- `cfg_sel`  in  1  register select: 0 = store base, 1 = store end.
- `cfg_data`  in  48  value written on `cfg_ld`.
- `cmd_start`  in  1  1-cycle pulse: IDLE→RUN.
- `cmd_stop`  in  1  1-cycle pulse: RUN→DRAIN.
- `req_mem_ld`, `req_mem_st`  out  1  registered request strobes.
- `req_mem_addr`  out  48  registered request address.
- `req_mem_d_or_tag`  out  64  registered store data or load tag.
- `req_mem_stall`  in  1  memory back-pressure.
- `rsp_mem_push`  in  1  one load response returned.
- `busy`  out  1  registered; 1 when state≠IDLE or outstanding≠0.
- `st_done`  out  1  registered; 1 when the store address equals the store end.

## Operation
- States:
  - IDLE: no grants; `cmd_start` → RUN.
  - RUN: full arbitration; `cmd_stop` → DRAIN.
  - DRAIN: stores only, no loads; → IDLE when outstanding==0 and `st_valid`==0.
- Grant eligibility, evaluated every cycle. A grant requires `req_mem_stall`==0 and state≠IDLE.
  - Store: `st_valid`.
  - Loads: additionally require state==RUN and outstanding<`MAX_OUT`.
- Priority: store > cache > decoder, except as overridden by the starvation guard (see Configuration).
- At most one of `st_ready`/`cl_ready`/`dl_ready` is high, and only for the granted requester. Each is combinational from valids, stall, state and counters; a transfer occurs when valid&&ready.
- Store transfer:
  - If st_addr≠st_end: next cycle `req_mem_st`=1, `req_mem_addr`=st_addr, `req_mem_d_or_tag`=`st_data`; st_addr += 8.
  - If st_addr==st_end: the data is accepted and dropped with no `req_mem_st`.
- Cache load transfer: `req_mem_ld`=1, addr=`cl_addr`, d_or_tag = 64'h1.
- Decoder load transfer: `req_mem_ld`=1, addr=`dl_addr`, d_or_tag = {61'b0, `dl_tag`, 1'b0}.
- Outstanding counter (6 bits for the default `MAX_OUT`):
  - +1 on each load transfer, −1 on `rsp_mem_push`.
  - Both in the same cycle: unchanged.
  - `rsp_mem_push` at 0: counter saturates at 0 and `busy` is unaffected.
- `cfg_ld`:
  - `cfg_sel`=0 writes st_addr; `cfg_sel`=1 writes st_end.
  - Accepted in any state.
  - A `cfg_ld` to st_addr in the same cycle as a store increment wins over the increment.
- `cmd_start` outside IDLE and `cmd_stop` outside RUN are ignored.
- Reset (`rst`=0):
  - State IDLE; st_addr, st_end, outstanding and the starve counter cleared.
  - All `req_mem_*` outputs 0; `busy`=0; `st_done`=1, since 0==0 after reset.
  - Reset asserted mid-operation discards in-flight requests; the responses that follow are not counted.

## Timing
- Handshake to `req_mem_*` visible: 1 cycle. The strobes are single-cycle pulses, with back-to-back grants on consecutive cycles.
- `req_mem_stall` is sampled in the same cycle as arbitration. A stalled cycle produces no grant and zero strobes in the next cycle.
- `busy` and `st_done` reflect state and counters with 1-cycle register latency.
- In cycles without a strobe, `req_mem_addr` and `req_mem_d_or_tag` hold their previous values.

## Configuration
- `SPMV_MEM_ARB_STARVE_GUARD_EN` defined:
  - A counter increments each cycle that `dl_valid` is high and not granted; it clears on a decoder grant or when `dl_valid` is low.
  - When the counter reaches `STARVE_LIMIT`, the decoder takes priority over cache and store for one grant, provided it is eligible.
- Undefined: strict store > cache > decoder priority; no counter logic.

## Test plan
- Reset, cfg st_addr=0x1000, st_end=0x1010, start, three stores D0..D2 → `req_mem_st` at 0x1000 (D0) and 0x1008 (D1); D2 accepted with no strobe; `st_done`=1.
- `st_valid`, `cl_valid` and `dl_valid` all held high in RUN → grant order is store first; cache wins only after `st_valid` drops; decoder d_or_tag = {dl_tag, 0}.
- `MAX_OUT`=4, five cache loads with no responses → four issued, `cl_ready`=0; one `rsp_mem_push` → fifth issues 1 cycle later.
- `req_mem_stall`=1 for 3 cycles with all valids high → no readies and no strobes; first grant on the cycle stall drops.
- Guard enabled, `cl_valid` and `dl_valid` held high → decoder granted on the 17th cycle of waiting (`STARVE_LIMIT`=16), then cache resumes.
- `cmd_stop` with 2 loads outstanding → loads blocked, `busy`=1; two `rsp_mem_push` pulses → IDLE; `busy`=0 one cycle later. Reset mid-RUN → all strobes 0 on the next cycle.

Source files
------------

// File: rtl/spmv_mem_arbiter.sv
// PE memory request arbiter: store / cache-load / decoder-load scheduling with a
// load credit counter. Define SPMV_MEM_ARB_STARVE_GUARD_EN to enable the decoder starvation guard.
module spmv_mem_arbiter #(
    parameter int MAX_OUT      = 32,
    parameter int STARVE_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [63:0] st_data,
    input  logic        cl_valid,
    output logic        cl_ready,
    input  logic [47:0] cl_addr,
    input  logic        dl_valid,
    output logic        dl_ready,
    input  logic [47:0] dl_addr,
    input  logic [1:0]  dl_tag,
    input  logic        cfg_ld,
    input  logic        cfg_sel,
    input  logic [47:0] cfg_data,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    output logic        req_mem_ld,
    output logic        req_mem_st,
    output logic [47:0] req_mem_addr,
    output logic [63:0] req_mem_d_or_tag,
    input  logic        req_mem_stall,
    input  logic        rsp_mem_push,
    output logic        busy,
    output logic        st_done,
    output logic [1:0]  dbg_state
);
    // Handshake: a transfer happens in a cycle where valid && ready; ready is
    // combinational and never depends on ready of another requester.
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [47:0]      st_addr, st_end;
    logic [OUT_W-1:0] outstanding;
    logic             can_grant, ld_ok, starve_hit;
    logic             st_grant, cl_grant, dl_grant, ld_xfer;

`ifdef SPMV_MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;

    assign starve_hit = (starve_cnt >= SW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!dl_valid || dl_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        st_grant  = 1'b0;
        cl_grant  = 1'b0;
        dl_grant  = 1'b0;
        can_grant = !req_mem_stall && (state != IDLE);
        ld_ok     = can_grant && (state == RUN) && (outstanding < OUT_W'(MAX_OUT));
        if (starve_hit && ld_ok && dl_valid) begin
            dl_grant = 1'b1;
        end else if (can_grant && st_valid) begin
            st_grant = 1'b1;
        end else if (ld_ok && cl_valid) begin
            cl_grant = 1'b1;
        end else if (ld_ok && dl_valid) begin
            dl_grant = 1'b1;
        end
        case (state)
            IDLE:    if (cmd_start) state_nxt = RUN;
            RUN:     if (cmd_stop) state_nxt = DRAIN;
            DRAIN:   if (outstanding == '0 && !st_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign st_ready  = st_grant;
    assign cl_ready  = cl_grant;
    assign dl_ready  = dl_grant;
    assign ld_xfer   = cl_grant || dl_grant;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            st_addr          <= '0;
            st_end           <= '0;
            outstanding      <= '0;
            req_mem_ld       <= 1'b0;
            req_mem_st       <= 1'b0;
            req_mem_addr     <= '0;
            req_mem_d_or_tag <= '0;
            busy             <= 1'b0;
            st_done          <= 1'b1;
        end else begin
            state      <= state_nxt;
            req_mem_ld <= 1'b0;
            req_mem_st <= 1'b0;
            busy       <= (state != IDLE) || (outstanding != '0);
            st_done    <= (st_addr == st_end);
            // A store to the end address is consumed but never reaches memory.
            if (st_grant && st_addr != st_end) begin
                req_mem_st       <= 1'b1;
                req_mem_addr     <= st_addr;
                req_mem_d_or_tag <= st_data;
                st_addr          <= st_addr + 48'd8;
            end else if (cl_grant) begin
                req_mem_ld       <= 1'b1;
                req_mem_addr     <= cl_addr;
                req_mem_d_or_tag <= 64'h1;
            end else if (dl_grant) begin
                req_mem_ld       <= 1'b1;
                req_mem_addr     <= dl_addr;
                req_mem_d_or_tag <= {61'b0, dl_tag, 1'b0};
            end
            if (cfg_ld && !cfg_sel) st_addr <= cfg_data;
            if (cfg_ld && cfg_sel)  st_end  <= cfg_data;
            if (ld_xfer && !rsp_mem_push) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (!ld_xfer && rsp_mem_push && outstanding != '0) begin
                outstanding <= outstanding - OUT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Table-driven bench for spmv_mem_arbiter (MAX_OUT=4) plus reset and starvation sequences.
module tb_spmv_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid, st_ready, cl_valid, cl_ready, dl_valid, dl_ready;
    logic [63:0] st_data;
    logic [47:0] cl_addr, dl_addr, cfg_data;
    logic [1:0]  dl_tag;
    logic        cfg_ld, cfg_sel, cmd_start, cmd_stop;
    logic        req_mem_ld, req_mem_st, req_mem_stall, rsp_mem_push, busy, st_done;
    logic [47:0] req_mem_addr;
    logic [63:0] req_mem_d_or_tag;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    spmv_mem_arbiter #(.MAX_OUT(4), .STARVE_LIMIT(16)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .cl_valid(cl_valid), .cl_ready(cl_ready), .cl_addr(cl_addr),
        .dl_valid(dl_valid), .dl_ready(dl_ready), .dl_addr(dl_addr), .dl_tag(dl_tag),
        .cfg_ld(cfg_ld), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .req_mem_ld(req_mem_ld), .req_mem_st(req_mem_st),
        .req_mem_addr(req_mem_addr), .req_mem_d_or_tag(req_mem_d_or_tag),
        .req_mem_stall(req_mem_stall), .rsp_mem_push(rsp_mem_push),
        .busy(busy), .st_done(st_done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // in_f  = {cfg_ld, cfg_sel, start, stop, st_valid, cl_valid, dl_valid, stall, push}
    // exp_f = {st_ready, cl_ready, dl_ready, req_ld, req_st, busy, st_done}
    typedef struct {
        logic [8:0]  in_f;
        logic [47:0] cfg;
        logic [63:0] sd;
        logic [47:0] cla;
        logic [47:0] dla;
        logic [1:0]  tag;
        logic [6:0]  exp_f;
        logic [47:0] e_addr;
        logic [63:0] e_d;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [8:0] in_f, input logic [47:0] cfg, input logic [63:0] sd,
                       input logic [47:0] cla, input logic [47:0] dla, input logic [1:0] tag,
                       input logic [6:0] exp_f, input logic [47:0] e_addr, input logic [63:0] e_d);
        vec_t v;
        v.in_f = in_f; v.cfg = cfg; v.sd = sd; v.cla = cla; v.dla = dla; v.tag = tag;
        v.exp_f = exp_f; v.e_addr = e_addr; v.e_d = e_d;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        st_valid = 0; cl_valid = 0; dl_valid = 0; cfg_ld = 0; cfg_sel = 0;
        cmd_start = 0; cmd_stop = 0; req_mem_stall = 0; rsp_mem_push = 0;
        st_data = '0; cl_addr = '0; dl_addr = '0; dl_tag = '0; cfg_data = '0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        {cfg_ld, cfg_sel, cmd_start, cmd_stop, st_valid, cl_valid, dl_valid,
         req_mem_stall, rsp_mem_push} = v.in_f;
        cfg_data = v.cfg; st_data = v.sd; cl_addr = v.cla; dl_addr = v.dla; dl_tag = v.tag;
        #1;
        chk($sformatf("v%0d readies", idx), {61'b0, st_ready, cl_ready, dl_ready}, {61'b0, v.exp_f[6:4]});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d flags", idx), {60'b0, req_mem_ld, req_mem_st, busy, st_done}, {60'b0, v.exp_f[3:0]});
        chk($sformatf("v%0d addr", idx), {16'b0, req_mem_addr}, {16'b0, v.e_addr});
        chk($sformatf("v%0d data", idx), req_mem_d_or_tag, v.e_d);
    endtask

    initial begin
        int first_dl;
        idle_inputs();
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset strobes", {62'b0, req_mem_ld, req_mem_st}, 64'd0);
        chk("reset busy/done", {62'b0, busy, st_done}, 64'd1);
        chk("reset state", {62'b0, dbg_state}, 64'd0);
        @(negedge clk);
        rst = 1;

        // Store stream, priority, credit limit, stall, drain, ignored commands.
        add(9'b1_0_0_0_000_00, 48'h1000, 0, 0, 0, 0, 7'b000_00_0_1, 48'h0, 64'h0);
        add(9'b1_1_0_0_000_00, 48'h1010, 0, 0, 0, 0, 7'b000_00_0_0, 48'h0, 64'h0);
        add(9'b0_0_1_0_000_00, 0, 0, 0, 0, 0, 7'b000_00_0_0, 48'h0, 64'h0);
        add(9'b0_0_0_0_100_00, 0, 64'hD0, 0, 0, 0, 7'b100_01_1_0, 48'h1000, 64'hD0);
        add(9'b0_0_0_0_100_00, 0, 64'hD1, 0, 0, 0, 7'b100_01_1_0, 48'h1008, 64'hD1);
        add(9'b0_0_0_0_100_00, 0, 64'hD2, 0, 0, 0, 7'b100_00_1_1, 48'h1008, 64'hD1);
        add(9'b1_1_0_0_000_00, 48'h2000, 0, 0, 0, 0, 7'b000_00_1_1, 48'h1008, 64'hD1);
        add(9'b0_0_0_0_111_00, 0, 64'h33, 48'hC00, 48'hD00, 2, 7'b100_01_1_0, 48'h1010, 64'h33);
        add(9'b0_0_0_0_111_00, 0, 64'h44, 48'hC00, 48'hD00, 2, 7'b100_01_1_0, 48'h1018, 64'h44);
        add(9'b0_0_0_0_011_00, 0, 0, 48'hC00, 48'hD00, 2, 7'b010_10_1_0, 48'hC00, 64'h1);
        add(9'b0_0_0_0_011_00, 0, 0, 48'hC08, 48'hD00, 2, 7'b010_10_1_0, 48'hC08, 64'h1);
        add(9'b0_0_0_0_001_00, 0, 0, 0, 48'hD00, 2, 7'b001_10_1_0, 48'hD00, 64'h4);
        add(9'b0_0_0_0_001_00, 0, 0, 0, 48'hD08, 1, 7'b001_10_1_0, 48'hD08, 64'h2);
        add(9'b0_0_0_0_010_00, 0, 0, 48'hC10, 0, 0, 7'b000_00_1_0, 48'hD08, 64'h2);
        add(9'b0_0_0_0_010_01, 0, 0, 48'hC10, 0, 0, 7'b000_00_1_0, 48'hD08, 64'h2);
        add(9'b0_0_0_0_010_00, 0, 0, 48'hC10, 0, 0, 7'b010_10_1_0, 48'hC10, 64'h1);
        add(9'b0_0_0_0_111_11, 0, 64'h55, 48'hC10, 48'hD10, 3, 7'b000_00_1_0, 48'hC10, 64'h1);
        add(9'b0_0_0_0_111_10, 0, 64'h55, 48'hC10, 48'hD10, 3, 7'b000_00_1_0, 48'hC10, 64'h1);
        add(9'b0_0_0_0_111_10, 0, 64'h55, 48'hC10, 48'hD10, 3, 7'b000_00_1_0, 48'hC10, 64'h1);
        add(9'b0_0_0_0_111_00, 0, 64'h55, 48'hC10, 48'hD10, 3, 7'b100_01_1_0, 48'h1020, 64'h55);
        add(9'b0_0_0_0_010_01, 0, 0, 48'hC18, 0, 0, 7'b010_10_1_0, 48'hC18, 64'h1);
        add(9'b0_0_0_0_000_01, 0, 0, 0, 0, 0, 7'b000_00_1_0, 48'hC18, 64'h1);
        add(9'b0_0_0_1_000_00, 0, 0, 0, 0, 0, 7'b000_00_1_0, 48'hC18, 64'h1);
        add(9'b0_0_0_0_011_00, 0, 0, 48'hC20, 48'hD20, 0, 7'b000_00_1_0, 48'hC18, 64'h1);
        add(9'b0_0_0_0_100_00, 0, 64'h66, 0, 0, 0, 7'b100_01_1_0, 48'h1028, 64'h66);
        add(9'b0_0_0_0_000_01, 0, 0, 0, 0, 0, 7'b000_00_1_0, 48'h1028, 64'h66);
        add(9'b0_0_0_0_000_01, 0, 0, 0, 0, 0, 7'b000_00_1_0, 48'h1028, 64'h66);
        add(9'b0_0_0_0_000_00, 0, 0, 0, 0, 0, 7'b000_00_1_0, 48'h1028, 64'h66);
        add(9'b0_0_0_0_100_00, 0, 64'h77, 0, 0, 0, 7'b000_00_0_0, 48'h1028, 64'h66);
        add(9'b0_0_0_0_010_01, 0, 0, 48'hC28, 0, 0, 7'b000_00_0_0, 48'h1028, 64'h66);
        add(9'b0_0_0_1_000_00, 0, 0, 0, 0, 0, 7'b000_00_0_0, 48'h1028, 64'h66);
        add(9'b0_0_1_0_000_00, 0, 0, 0, 0, 0, 7'b000_00_0_0, 48'h1028, 64'h66);
        add(9'b1_0_0_0_100_00, 48'h3000, 64'h88, 0, 0, 0, 7'b100_01_1_0, 48'h1030, 64'h88);
        add(9'b0_0_0_0_100_00, 0, 64'h99, 0, 0, 0, 7'b100_01_1_0, 48'h3000, 64'h99);

        foreach (vecs[i]) apply(vecs[i], i);
        chk("state after table", {62'b0, dbg_state}, 64'd1);

        // Reset mid-RUN with a load just issued and requesters still pending.
        @(negedge clk);
        idle_inputs();
        cl_valid = 1; cl_addr = 48'hC30;
        @(posedge clk); #1;
        chk("pre-reset load", {63'b0, req_mem_ld}, 64'd1);
        @(negedge clk);
        rst = 0; st_valid = 1; st_data = 64'hAA;
        @(posedge clk); #1;
        chk("mid-reset strobes", {62'b0, req_mem_ld, req_mem_st}, 64'd0);
        chk("mid-reset busy/done", {62'b0, busy, st_done}, 64'd1);
        chk("mid-reset addr", {16'b0, req_mem_addr}, 64'd0);
        @(negedge clk);
        rst = 1; idle_inputs(); rsp_mem_push = 1;
        @(negedge clk);
        rsp_mem_push = 0;
        @(posedge clk); #1;
        chk("stale push busy", {63'b0, busy}, 64'd0);

        // Cache and decoder held high with responses returning every cycle.
        @(negedge clk);
        cmd_start = 1;
        @(negedge clk);
        cmd_start = 0; cl_valid = 1; dl_valid = 1; cl_addr = 48'hE00; dl_addr = 48'hF00;
        rsp_mem_push = 1;
        first_dl = 0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (dl_ready && first_dl == 0) first_dl = c;
            if (c == 18) begin
`ifdef SPMV_MEM_ARB_STARVE_GUARD_EN
                chk("cache resumes", {63'b0, cl_ready}, 64'd1);
`else
                chk("cache holds", {63'b0, cl_ready}, 64'd1);
`endif
            end
            @(negedge clk);
        end
`ifdef SPMV_MEM_ARB_STARVE_GUARD_EN
        chk("starve grant cycle", 64'(first_dl), 64'd17);
`else
        chk("no decoder grant", 64'(first_dl), 64'd0);
`endif
        idle_inputs();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
